// File: rtl/viexo_textcon_pkg.sv
// Shared types and constants for the 80x30 text console write sequencer.
package viexo_textcon_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_CLRLINE
    } state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

endpackage

// File: rtl/viexo_textcon_fill.sv
// Blank-fill address engine: walks start_addr..start_addr+last, one step per granted cycle.
module viexo_textcon_fill #(
    parameter int ADDR_W   = 12,
    parameter int RST_LAST = 2399
) (
    input  logic              pclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] last,
    input  logic              active,
    input  logic              wr_allow,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] last_q;
    logic              step;

    assign step = active && wr_allow;
    assign done = step && (cnt == last_q);

    // Reset state is a full-screen clear from address 0.
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            addr   <= '0;
            cnt    <= '0;
            last_q <= ADDR_W'(RST_LAST);
        end else if (start) begin
            addr   <= start_addr;
            cnt    <= '0;
            last_q <= last;
        end else if (step && !done) begin
            addr <= addr + 1'b1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/viexo_textcon.sv
// Console write sequencer: interprets a byte stream and drives single-byte writes
// into the 80x30 character buffer whenever the display side grants the port.
module viexo_textcon
    import viexo_textcon_pkg::*;
#(
    parameter int         COLS       = COLS_DEF,
    parameter int         ROWS       = ROWS_DEF,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic              pclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_char,
    input  logic              wr_allow,
    output logic              wen,
    output logic [ADDR_W-1:0] wputhere,
    output logic [7:0]        wput_c,
    output logic [6:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy
);

    localparam int                TOTAL     = COLS * ROWS;
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_SCR  = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);

    state_t            state;
    logic [6:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] put_addr;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_base;
    logic [ADDR_W-1:0] fill_start_addr;
    logic [ADDR_W-1:0] fill_last;
    logic              put_adv;
    logic              fill_done;
    logic              fill_start;
    logic              accept;
    logic              printable;
    logic              wrap;

    assign accept    = s_valid && (state == ST_IDLE);
    assign printable = (s_char >= 8'h20) && (s_char <= 8'h7E);
    assign wrap      = (row == LAST_ROW);
    assign next_base = wrap ? '0 : line_base + COLS_A;
    assign cur_addr  = line_base + ADDR_W'(col);

    always_comb begin
        fill_start      = 1'b0;
        fill_start_addr = next_base;
        fill_last       = LAST_LINE;
        if (accept && s_char == CH_FF) begin
            fill_start      = 1'b1;
            fill_start_addr = '0;
            fill_last       = LAST_SCR;
        end else if (accept && s_char == CH_LF) begin
            fill_start = 1'b1;
        end else if (state == ST_PUT && wr_allow && put_adv && col == LAST_COL) begin
            fill_start = 1'b1;
        end
    end

    viexo_textcon_fill #(
        .ADDR_W   (ADDR_W),
        .RST_LAST (TOTAL - 1)
    ) u_fill (
        .pclk       (pclk),
        .aresetn    (aresetn),
        .start      (fill_start),
        .start_addr (fill_start_addr),
        .last       (fill_last),
        .active     (state == ST_CLEAR || state == ST_CLRLINE),
        .wr_allow   (wr_allow),
        .addr       (fill_addr),
        .done       (fill_done)
    );

    // put_adv distinguishes a printable write (cursor advances) from a backspace blank.
    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_CLEAR;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            put_addr  <= '0;
            put_adv   <= 1'b0;
            wput_c    <= BLANK_CHAR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            put_addr <= cur_addr;
                            wput_c   <= s_char;
                            put_adv  <= 1'b1;
                            state    <= ST_PUT;
                        end else begin
                            case (s_char)
                                CH_LF: begin
                                    col       <= '0;
                                    row       <= wrap ? '0 : row + 5'd1;
                                    line_base <= next_base;
                                    wput_c    <= BLANK_CHAR;
                                    state     <= ST_CLRLINE;
                                end
                                CH_CR: col <= '0;
                                CH_BS: begin
                                    if (col != '0) begin
                                        col      <= col - 7'd1;
                                        put_addr <= cur_addr - 1'b1;
                                        wput_c   <= BLANK_CHAR;
                                        put_adv  <= 1'b0;
                                        state    <= ST_PUT;
                                    end
                                end
                                CH_FF: begin
                                    col       <= '0;
                                    row       <= '0;
                                    line_base <= '0;
                                    wput_c    <= BLANK_CHAR;
                                    state     <= ST_CLEAR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_PUT: begin
                    if (wr_allow) begin
                        if (!put_adv) begin
                            state <= ST_IDLE;
                        end else if (col != LAST_COL) begin
                            col   <= col + 7'd1;
                            state <= ST_IDLE;
                        end else begin
                            col       <= '0;
                            row       <= wrap ? '0 : row + 5'd1;
                            line_base <= next_base;
                            wput_c    <= BLANK_CHAR;
                            state     <= ST_CLRLINE;
                        end
                    end
                end
                ST_CLEAR, ST_CLRLINE: begin
                    if (fill_done) state <= ST_IDLE;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Reset gates the strobe directly so an in-flight write is dropped at once.
    assign wen      = aresetn && (state != ST_IDLE) && wr_allow;
    assign wputhere = (state == ST_PUT) ? put_addr : fill_addr;
    assign s_ready  = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign cur_col  = col;
    assign cur_row  = row;

endmodule

// File: tb/tb_viexo_textcon.sv
// Directed bench for viexo_textcon: clears, printing, wrap/scroll, write gating, BS/CR, reset abort.
module tb_viexo_textcon;

    logic        pclk = 1'b0;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_char;
    logic        wr_allow;
    logic        wen;
    logic [11:0] wputhere;
    logic [7:0]  wput_c;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [11:0] qa[$];
    logic [7:0]  qd[$];

    viexo_textcon dut (
        .pclk     (pclk),
        .aresetn  (aresetn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_char   (s_char),
        .wr_allow (wr_allow),
        .wen      (wen),
        .wputhere (wputhere),
        .wput_c   (wput_c),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (wen) begin
            qa.push_back(wputhere);
            qd.push_back(wput_c);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!s_ready && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(s_ready), 32'd1);
    endtask

    // Present a byte, hold until accepted, then return one step after the accepting edge.
    task automatic send(input logic [7:0] c);
        s_valid = 1'b1;
        s_char  = c;
        wait_idle("send");
        step();
        s_valid = 1'b0;
    endtask

    task automatic check_full_clear(input string tag);
        int first_bad = -1;
        chk({tag, "_count"}, 32'(qa.size()), 32'd2400);
        for (int i = 0; i < qa.size(); i++) begin
            if (first_bad < 0 && (qa[i] !== 12'(i) || qd[i] !== 8'h20)) first_bad = i;
        end
        chk({tag, "_order"}, 32'(first_bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        aresetn  = 1'b0;
        s_valid  = 1'b0;
        s_char   = 8'h00;
        wr_allow = 1'b1;
        #12;
        chk("rst_wen",      32'(wen),      32'd0);
        chk("rst_s_ready",  32'(s_ready),  32'd0);
        chk("rst_wputhere", 32'(wputhere), 32'd0);
        chk("rst_wput_c",   32'(wput_c),   32'h20);
        chk("rst_col",      32'(cur_col),  32'd0);
        chk("rst_row",      32'(cur_row),  32'd0);
        chk("rst_busy",     32'(busy),     32'd1);

        // 1: power-on clear
        @(posedge pclk);
        #1 aresetn = 1'b1;
        wait_idle("clr1");
        check_full_clear("clr1");
        chk("clr1_busy", 32'(busy), 32'd0);

        // 2: "Hi" with latency check
        qa.delete(); qd.delete();
        send(8'h48);
        chk("h_wen",      32'(wen),      32'd1);
        chk("h_s_ready",  32'(s_ready),  32'd0);
        chk("h_wputhere", 32'(wputhere), 32'd0);
        chk("h_wput_c",   32'(wput_c),   32'h48);
        step();
        chk("h_ready_n2", 32'(s_ready),  32'd1);
        send(8'h69);
        wait_idle("hi");
        chk("hi_count", 32'(qa.size()), 32'd2);
        chk("hi_a0", 32'(qa[0]), 32'd0);
        chk("hi_d0", 32'(qd[0]), 32'h48);
        chk("hi_a1", 32'(qa[1]), 32'd1);
        chk("hi_d1", 32'(qd[1]), 32'h69);
        chk("hi_col", 32'(cur_col), 32'd2);
        chk("hi_row", 32'(cur_row), 32'd0);

        // 3: move to row 29 col 0, then fill the last row and wrap
        send(8'h0D);
        wait_idle("cr0");
        chk("cr0_col", 32'(cur_col), 32'd0);
        for (int i = 0; i < 29; i++) begin
            send(8'h0A);
            wait_idle("lf");
        end
        chk("lf_row", 32'(cur_row), 32'd29);
        qa.delete(); qd.delete();
        for (int i = 0; i < 80; i++) begin
            send(8'h41);
        end
        wait_idle("wrap");
        chk("wrap_count",  32'(qa.size()), 32'd160);
        chk("wrap_first",  32'(qa[0]),  32'd2320);
        chk("wrap_last_a", 32'(qa[79]), 32'd2399);
        chk("wrap_last_d", 32'(qd[79]), 32'h41);
        begin
            int first_bad = -1;
            for (int i = 80; i < qa.size(); i++) begin
                if (first_bad < 0 && (qa[i] !== 12'(i - 80) || qd[i] !== 8'h20)) first_bad = i;
            end
            chk("wrap_clrline", 32'(first_bad), 32'hFFFF_FFFF);
        end
        chk("wrap_row", 32'(cur_row), 32'd0);
        chk("wrap_col", 32'(cur_col), 32'd0);

        // 4: 'Z' under a 1-of-4 write grant
        qa.delete(); qd.delete();
        wr_allow = 1'b0;
        send(8'h5A);
        for (int i = 0; i < 3; i++) begin
            chk("z_wen_blocked", 32'(wen),      32'd0);
            chk("z_addr_stable", 32'(wputhere), 32'd0);
            chk("z_data_stable", 32'(wput_c),   32'h5A);
            chk("z_col_held",    32'(cur_col),  32'd0);
            step();
        end
        wr_allow = 1'b1;
        #1;
        chk("z_wen_allowed", 32'(wen), 32'd1);
        step();
        wr_allow = 1'b0;
        #1;
        chk("z_ready",  32'(s_ready),   32'd1);
        chk("z_count",  32'(qa.size()), 32'd1);
        chk("z_col",    32'(cur_col),   32'd1);
        wr_allow = 1'b1;

        // 5: to col 5, then BS, CR, BS
        for (int i = 0; i < 4; i++) send(8'h62);
        wait_idle("b4");
        chk("b4_col", 32'(cur_col), 32'd5);
        qa.delete(); qd.delete();
        send(8'h08);
        wait_idle("bs1");
        chk("bs1_col", 32'(cur_col), 32'd4);
        send(8'h0D);
        wait_idle("cr");
        chk("cr_col", 32'(cur_col), 32'd0);
        send(8'h08);
        step();
        wait_idle("bs2");
        chk("bs_count", 32'(qa.size()), 32'd1);
        chk("bs_addr",  32'(qa[0]),     32'd4);
        chk("bs_data",  32'(qd[0]),     32'h20);
        chk("bs2_col",  32'(cur_col),   32'd0);

        // 6: reset in the middle of a line clear
        send(8'h0A);
        repeat (5) step();
        chk("mid_row",  32'(cur_row), 32'd1);
        chk("mid_wen",  32'(wen),     32'd1);
        aresetn = 1'b0;
        #1;
        chk("abort_wen",   32'(wen),      32'd0);
        chk("abort_busy",  32'(busy),     32'd1);
        chk("abort_row",   32'(cur_row),  32'd0);
        chk("abort_wputhere", 32'(wputhere), 32'd0);
        qa.delete(); qd.delete();
        step();
        step();
        aresetn = 1'b1;
        wait_idle("clr2");
        check_full_clear("clr2");
        chk("clr2_col", 32'(cur_col), 32'd0);
        chk("clr2_row", 32'(cur_row), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
